// File: rtl/mem_pkg.sv
// Shared types and constants for the memory interconnect slice.
// Size encodings, FSM states and region/wait-counter limits.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int unsigned MAX_REGIONS  = 4;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned REGION_IDX_W = $clog2(MAX_REGIONS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_t;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/mem_interconnect_if.sv
// Core request/response handshake plus the shared region target bus.
// The interconnect uses the slave modport; the core/regions side uses master.
interface mem_interconnect_if #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned N_REGIONS = 2
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic [XLEN-1:0]           req_addr;
  logic [XLEN-1:0]           req_wdata;
  logic                      resp_valid;
  logic [XLEN-1:0]           resp_rdata;
  logic                      resp_err;
  logic [XLEN-1:0]           tgt_addr;
  logic [XLEN-1:0]           tgt_wdata;
  logic [XLEN/8-1:0]         tgt_be;
  logic [N_REGIONS-1:0]      tgt_we;
  logic [N_REGIONS*XLEN-1:0] tgt_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, tgt_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           tgt_addr, tgt_wdata, tgt_be, tgt_we
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, tgt_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           tgt_addr, tgt_wdata, tgt_be, tgt_we
  );
endinterface

// File: rtl/mem_region_decode.sv
// Combinational address decoder: hit flag, selected region and region offset.
// The lowest-index matching region wins when regions overlap.
module mem_region_decode
  import mem_pkg::*;
#(
  parameter int unsigned               XLEN        = 64,
  parameter int unsigned               N_REGIONS   = 2,
  parameter logic [N_REGIONS*XLEN-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*XLEN-1:0] REGION_SIZE = '1
) (
  input  logic [XLEN-1:0]         addr,
  output logic                    hit,
  output logic [REGION_IDX_W-1:0] sel,
  output logic [XLEN-1:0]         offset
);

  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    offset = '0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      // addr >= base is tested first, so the subtraction never wraps
      if (!hit && (addr >= REGION_BASE[i*XLEN +: XLEN]) &&
          ((addr - REGION_BASE[i*XLEN +: XLEN]) < REGION_SIZE[i*XLEN +: XLEN])) begin
        hit    = 1'b1;
        sel    = REGION_IDX_W'(i);
        offset = addr - REGION_BASE[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/mem_interconnect.sv
// Core memory port to N regions: decode, fault checks, wait states and byte lanes.
// FSM IDLE -> ACCESS (W+1 cycles) -> RESP, or IDLE -> RESP on a fault.
module mem_interconnect
  import mem_pkg::*;
#(
  parameter int unsigned                 XLEN        = 64,
  parameter int unsigned                 N_REGIONS   = 2,
  parameter logic [N_REGIONS*XLEN-1:0]   REGION_BASE = {64'h2000, 64'h0},
  parameter logic [N_REGIONS*XLEN-1:0]   REGION_SIZE = {64'h2000, 64'h2000},
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT = {4'd1, 4'd0},
  parameter logic [N_REGIONS-1:0]        REGION_RO   = 2'b01
) (
  input logic               clk,
  input logic               reset,
  mem_interconnect_if.slave bus
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  mem_state_t state_q, state_d;

  logic [WAIT_W-1:0]       cnt_q;
  logic [REGION_IDX_W-1:0] sel_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic [OFF_W-1:0]        off_q;
  logic                    resp_err_q;
  logic [XLEN-1:0]         resp_rdata_q, tgt_addr_q, tgt_wdata_q;
  logic [NB-1:0]           tgt_be_q;

  logic                    dec_hit;
  logic [REGION_IDX_W-1:0] dec_sel;
  logic [XLEN-1:0]         dec_off;

  mem_region_decode #(
    .XLEN        (XLEN),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .addr   (bus.req_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_off)
  );

  logic [OFF_W-1:0]     req_off;
  int unsigned          req_nb, nb_q;
  logic                 sel_ro, fault, last_access;
  logic [WAIT_W-1:0]    sel_wait;
  logic [XLEN-1:0]      sel_rdata, wdata_req, rdata_shift, load_data;
  logic [NB-1:0]        be_req;
  logic [N_REGIONS-1:0] we_onehot;

  assign req_off     = bus.req_addr[OFF_W-1:0];
  assign req_nb      = size_bytes(bus.req_size);
  assign nb_q        = size_bytes(size_q);
  assign last_access = (state_q == ACCESS) && (cnt_q == '0);

  // Per-region parameter lookup by decoded index, and read/write steering by latched index
  always_comb begin
    sel_ro    = 1'b0;
    sel_wait  = '0;
    sel_rdata = '0;
    we_onehot = '0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      if (dec_sel == REGION_IDX_W'(i)) begin
        sel_ro   = REGION_RO[i];
        sel_wait = REGION_WAIT[i*WAIT_W +: WAIT_W];
      end
      if (sel_q == REGION_IDX_W'(i)) begin
        sel_rdata    = bus.tgt_rdata[i*XLEN +: XLEN];
        we_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    fault = !dec_hit
         || ((int'(req_off) & int'(req_nb - 1)) != 0)
         || ((XLEN == 32) && (bus.req_size == SZ_D))
         || (bus.req_we && sel_ro);
    wdata_req   = bus.req_wdata << {req_off, 3'b000};
    rdata_shift = sel_rdata >> {off_q, 3'b000};
    be_req      = '0;
    load_data   = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be_req[b]          = (b >= int'(req_off)) && (b < int'(req_off) + req_nb);
      load_data[b*8 +: 8] = (b < nb_q) ? rdata_shift[b*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = (state_q == IDLE) && !reset;
    bus.resp_valid = (state_q == RESP);
    bus.tgt_we     = (last_access && we_q && !reset) ? we_onehot : '0;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = fault ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      tgt_addr_q   <= '0;
      tgt_wdata_q  <= '0;
      tgt_be_q     <= '0;
    end else if (state_q == IDLE && bus.req_valid) begin
      cnt_q        <= sel_wait;
      sel_q        <= dec_sel;
      we_q         <= bus.req_we;
      size_q       <= bus.req_size;
      off_q        <= req_off;
      resp_err_q   <= fault;
      resp_rdata_q <= '0;
      // Target bus only moves for accesses that will reach a region
      if (!fault) begin
        tgt_addr_q  <= dec_off;
        tgt_wdata_q <= wdata_req;
        tgt_be_q    <= be_req;
      end
    end else if (state_q == ACCESS) begin
      if (cnt_q != '0)  cnt_q        <= cnt_q - 1'b1;
      else if (!we_q)   resp_rdata_q <= load_data;
    end
  end

  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.tgt_addr   = tgt_addr_q;
  assign bus.tgt_wdata  = tgt_wdata_q;
  assign bus.tgt_be     = tgt_be_q;

endmodule

// File: tb/tb_mem_interconnect.sv
// Bench for mem_interconnect: default two-region instance plus a three-region overlap instance.
// A per-cycle expectation table filled from the address map drives a single compare process.
module tb_mem_interconnect;
  import mem_pkg::*;

  localparam int NCYC = 256;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_interconnect_if #(.XLEN(64), .N_REGIONS(2)) bus_a ();
  mem_interconnect_if #(.XLEN(64), .N_REGIONS(3)) bus_b ();

  mem_interconnect dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  mem_interconnect #(
    .XLEN        (64),
    .N_REGIONS   (3),
    .REGION_BASE ({64'h2000, 64'h2000, 64'h0}),
    .REGION_SIZE ({64'h1000, 64'h2000, 64'h2000}),
    .REGION_WAIT ({4'd0, 4'd1, 4'd0}),
    .REGION_RO   (3'b001)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  // Address map and region contents as the bench sees them
  logic [63:0] m_base [2][4];
  logic [63:0] m_size [2][4];
  int          m_wait [2][4];
  bit          m_ro   [2][4];
  logic [63:0] m_data [2][4];
  int          m_n    [2];

  // Expected behaviour per DUT per cycle
  bit          e_ready [2][NCYC];
  bit          e_valid [2][NCYC];
  bit          e_err   [2][NCYC];
  bit          e_chkrd [2][NCYC];
  logic [63:0] e_rd    [2][NCYC];
  logic [3:0]  e_we    [2][NCYC];
  bit          e_acc   [2][NCYC];
  logic [63:0] e_addr  [2][NCYC];
  logic [7:0]  e_be    [2][NCYC];
  logic [63:0] e_wd    [2][NCYC];

  task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (dut%0d cyc %0d): got %0h, expected %0h", nm, d, cyc, act, exp);
  endtask

  task automatic model_req(input int d, input int a, input bit we, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wdata, output int lat);
    int sel = -1;
    int nb  = 1 << sz;
    int off = int'(addr % 8);
    bit flt;
    for (int i = 0; i < m_n[d]; i++)
      if (sel < 0 && addr >= m_base[d][i] && (addr - m_base[d][i]) < m_size[d][i]) sel = i;
    flt = (sel < 0) || ((addr % nb) != 0);
    if (!flt && we && m_ro[d][sel]) flt = 1'b1;
    if (flt) begin
      lat = 1;
      e_ready[d][a+1] = 1'b0;
      e_valid[d][a+1] = 1'b1;
      e_err[d][a+1]   = 1'b1;
      e_chkrd[d][a+1] = 1'b1;
      e_rd[d][a+1]    = '0;
    end else begin
      int w = m_wait[d][sel];
      logic [63:0] mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
      lat = w + 2;
      for (int k = 1; k <= w + 1; k++) begin
        e_ready[d][a+k] = 1'b0;
        e_acc[d][a+k]   = 1'b1;
        e_addr[d][a+k]  = addr - m_base[d][sel];
        e_be[d][a+k]    = 8'(((1 << nb) - 1) << off);
        e_wd[d][a+k]    = wdata << (8 * off);
      end
      e_we[d][a+w+1]    = we ? 4'(1 << sel) : 4'd0;
      e_ready[d][a+w+2] = 1'b0;
      e_valid[d][a+w+2] = 1'b1;
      e_err[d][a+w+2]   = 1'b0;
      e_chkrd[d][a+w+2] = !we;
      e_rd[d][a+w+2]    = (m_data[d][sel] >> (8 * off)) & mask;
    end
  endtask

  task automatic model_reset(input int d, input int r);
    e_ready[d][r] = 1'b0;
    e_we[d][r]    = '0;
    for (int c = r + 1; c < NCYC; c++) begin
      e_ready[d][c] = 1'b1;
      e_valid[d][c] = 1'b0;
      e_we[d][c]    = '0;
      e_acc[d][c]   = 1'b0;
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns at the first cycle after acceptance
  task automatic drive_req(input int d, input bit we, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wdata, output int a, output int lat);
    a = cyc;
    if (d == 0) begin
      bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_size = sz;
      bus_a.req_addr = addr; bus_a.req_wdata = wdata;
    end else begin
      bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_size = sz;
      bus_b.req_addr = addr; bus_b.req_wdata = wdata;
    end
    model_req(d, a, we, sz, addr, wdata, lat);
    @(posedge clk); #1;
    if (d == 0) begin
      bus_a.req_valid = 1'b0; bus_a.req_we = ~we; bus_a.req_addr = 64'h4000;
    end else begin
      bus_b.req_valid = 1'b0; bus_b.req_we = ~we; bus_b.req_addr = 64'h4000;
    end
  endtask

  task automatic finish_req(input int a, input int lat);
    while (cyc <= a + lat) begin @(posedge clk); #1; end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic        rdy, vld, err;
    logic [63:0] rd, ad, wd;
    logic [7:0]  be;
    logic [3:0]  we;
    if (cyc >= 1 && cyc < NCYC) begin
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          rdy = bus_a.req_ready; vld = bus_a.resp_valid; err = bus_a.resp_err; rd = bus_a.resp_rdata;
          ad = bus_a.tgt_addr; wd = bus_a.tgt_wdata; be = bus_a.tgt_be; we = {2'b00, bus_a.tgt_we};
        end else begin
          rdy = bus_b.req_ready; vld = bus_b.resp_valid; err = bus_b.resp_err; rd = bus_b.resp_rdata;
          ad = bus_b.tgt_addr; wd = bus_b.tgt_wdata; be = bus_b.tgt_be; we = {1'b0, bus_b.tgt_we};
        end
        check("req_ready", d, 64'(rdy), 64'(e_ready[d][cyc]));
        check("resp_valid", d, 64'(vld), 64'(e_valid[d][cyc]));
        check("tgt_we", d, 64'(we), 64'(e_we[d][cyc]));
        if (e_valid[d][cyc]) begin
          check("resp_err", d, 64'(err), 64'(e_err[d][cyc]));
          if (e_chkrd[d][cyc]) check("resp_rdata", d, rd, e_rd[d][cyc]);
        end
        if (e_acc[d][cyc]) begin
          check("tgt_addr", d, ad, e_addr[d][cyc]);
          check("tgt_be", d, 64'(be), 64'(e_be[d][cyc]));
          check("tgt_wdata", d, wd, e_wd[d][cyc]);
        end
      end
    end
  end

  initial begin
    int a, lat;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCYC; c++) begin
        e_ready[d][c] = (c >= 3); e_valid[d][c] = 1'b0; e_err[d][c] = 1'b0; e_chkrd[d][c] = 1'b0;
        e_rd[d][c] = '0; e_we[d][c] = '0; e_acc[d][c] = 1'b0;
        e_addr[d][c] = '0; e_be[d][c] = '0; e_wd[d][c] = '0;
      end
      for (int i = 0; i < 4; i++) begin
        m_base[d][i] = '0; m_size[d][i] = '0; m_wait[d][i] = 0; m_ro[d][i] = 1'b0; m_data[d][i] = '0;
      end
    end
    m_n[0] = 2;
    m_base[0][0] = 64'h0;    m_size[0][0] = 64'h2000; m_wait[0][0] = 0; m_ro[0][0] = 1'b1;
    m_base[0][1] = 64'h2000; m_size[0][1] = 64'h2000; m_wait[0][1] = 1;
    m_data[0][0] = 64'h00000000DEADBEEF;
    m_data[0][1] = 64'h1122334455667788;
    m_n[1] = 3;
    m_base[1][0] = 64'h0;    m_size[1][0] = 64'h2000; m_wait[1][0] = 0; m_ro[1][0] = 1'b1;
    m_base[1][1] = 64'h2000; m_size[1][1] = 64'h2000; m_wait[1][1] = 1;
    m_base[1][2] = 64'h2000; m_size[1][2] = 64'h1000; m_wait[1][2] = 0;
    m_data[1][0] = 64'h0F0E0D0C0B0A0908;
    m_data[1][1] = 64'h0BADF00DCAFEF00D;
    m_data[1][2] = 64'hAAAAAAAAAAAAAAAA;

    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = '0;
    bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_a.tgt_rdata = {m_data[0][1], m_data[0][0]};
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = '0;
    bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.tgt_rdata = {m_data[1][2], m_data[1][1], m_data[1][0]};

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("rst req_ready", 0, 64'(bus_a.req_ready), 64'd1);
    check("rst resp_valid", 0, 64'(bus_a.resp_valid), 64'd0);
    check("rst resp_err", 0, 64'(bus_a.resp_err), 64'd0);
    check("rst resp_rdata", 0, bus_a.resp_rdata, 64'd0);
    check("rst tgt_we", 0, 64'(bus_a.tgt_we), 64'd0);
    check("rst tgt_be", 0, 64'(bus_a.tgt_be), 64'd0);
    check("rst tgt_addr", 0, bus_a.tgt_addr, 64'd0);
    check("rst tgt_wdata", 0, bus_a.tgt_wdata, 64'd0);
    step();

    // IM word load, W=0
    drive_req(0, 1'b0, SZ_W, 64'h10, 64'h0, a, lat);
    check("im_ld tgt_addr", 0, bus_a.tgt_addr, 64'h10);
    check("im_ld early valid", 0, 64'(bus_a.resp_valid), 64'd0);
    step();
    check("im_ld valid", 0, 64'(bus_a.resp_valid), 64'd1);
    check("im_ld rdata", 0, bus_a.resp_rdata, 64'hDEADBEEF);
    check("im_ld err", 0, 64'(bus_a.resp_err), 64'd0);
    finish_req(a, lat);

    // DM byte store, W=1
    drive_req(0, 1'b1, SZ_B, 64'h2003, 64'hA5, a, lat);
    check("st_b tgt_addr", 0, bus_a.tgt_addr, 64'h3);
    check("st_b tgt_be", 0, 64'(bus_a.tgt_be), 64'h08);
    check("st_b tgt_wdata", 0, bus_a.tgt_wdata, 64'hA5000000);
    check("st_b we first", 0, 64'(bus_a.tgt_we), 64'd0);
    step();
    check("st_b we second", 0, 64'(bus_a.tgt_we), 64'b10);
    step();
    check("st_b valid", 0, 64'(bus_a.resp_valid), 64'd1);
    finish_req(a, lat);

    // Faults: RO store, misaligned half, unmapped
    drive_req(0, 1'b1, SZ_W, 64'h0, 64'h12345678, a, lat);
    check("ro valid", 0, 64'(bus_a.resp_valid), 64'd1);
    check("ro err", 0, 64'(bus_a.resp_err), 64'd1);
    finish_req(a, lat);
    drive_req(0, 1'b0, SZ_H, 64'h2001, 64'h0, a, lat);
    check("misal err", 0, 64'(bus_a.resp_err), 64'd1);
    finish_req(a, lat);
    drive_req(0, 1'b0, SZ_W, 64'h4000, 64'h0, a, lat);
    check("unmap err", 0, 64'(bus_a.resp_err), 64'd1);
    check("unmap rdata", 0, bus_a.resp_rdata, 64'd0);
    finish_req(a, lat);

    // Sub-word loads with lane shift and mask
    drive_req(0, 1'b0, SZ_H, 64'h2006, 64'h0, a, lat);
    step(); step();
    check("ld_h rdata", 0, bus_a.resp_rdata, 64'h1122);
    finish_req(a, lat);
    drive_req(0, 1'b0, SZ_B, 64'h2005, 64'h0, a, lat);
    finish_req(a, lat);
    drive_req(0, 1'b1, SZ_D, 64'h2008, 64'h0102030405060708, a, lat);
    finish_req(a, lat);

    // Reset during the first ACCESS cycle of a DM store
    drive_req(0, 1'b1, SZ_D, 64'h2010, 64'hCAFE, a, lat);
    rst_a = 1'b1;
    model_reset(0, cyc);
    step();
    rst_a = 1'b0;
    #1;
    check("abort ready", 0, 64'(bus_a.req_ready), 64'd1);
    repeat (3) step();
    drive_req(0, 1'b0, SZ_W, 64'h14, 64'h0, a, lat);
    finish_req(a, lat);

    // Overlapping regions: region 1 wins over region 2
    drive_req(1, 1'b0, SZ_D, 64'h2000, 64'h0, a, lat);
    step();
    check("ovl early valid", 1, 64'(bus_b.resp_valid), 64'd0);
    step();
    check("ovl valid", 1, 64'(bus_b.resp_valid), 64'd1);
    check("ovl rdata", 1, bus_b.resp_rdata, 64'h0BADF00DCAFEF00D);
    finish_req(a, lat);
    drive_req(1, 1'b1, SZ_W, 64'h2100, 64'h55AA55AA, a, lat);
    step();
    check("ovl st we", 1, 64'(bus_b.tgt_we), 64'b010);
    finish_req(a, lat);
    drive_req(1, 1'b0, SZ_W, 64'h10, 64'h0, a, lat);
    finish_req(a, lat);

    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
